// File: rtl/modbus_holding_regs_if.sv
// Register-bank bus between the Modbus function handler (master) and the
// holding-register bank (slave): write beats, write completion and reads.
interface modbus_holding_regs_if;
    // No backpressure: every cycle with reg_wen high carries one beat, and the
    // bank takes it unless a commit is in progress (then it is dropped).
    // reg_w_done is a one-cycle completion pulse qualifying reg_w_status.
    // rd_en samples rd_addr; rd_data/rd_err hold until the next rd_en.
    logic        reg_wen;
    logic [15:0] reg_waddr;
    logic [15:0] reg_wdat;
    logic        reg_wlast;
    logic        reg_wabort;
    logic        reg_w_done;
    logic        reg_w_status;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_err;

    modport master (
        output reg_wen, reg_waddr, reg_wdat, reg_wlast, reg_wabort, rd_en, rd_addr,
        input  reg_w_done, reg_w_status, rd_data, rd_err
    );

    modport slave (
        input  reg_wen, reg_waddr, reg_wdat, reg_wlast, reg_wabort, rd_en, rd_addr,
        output reg_w_done, reg_w_status, rd_data, rd_err
    );
endinterface

// File: rtl/modbus_holding_regs.sv
// Modbus holding-register bank: bursts are staged in a shadow buffer and
// committed atomically when every beat was legal; a host port also writes regs.
module modbus_holding_regs #(
    parameter int                    N_REGS       = 8,
    parameter logic [15:0]           BASE_ADDR    = 16'h0000,
    parameter logic [16*N_REGS-1:0]  RESET_VALUES = '0,
    parameter logic [N_REGS-1:0]     WR_MASK      = '1,
    parameter int                    IDX_W        = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    modbus_holding_regs_if.slave  bus,
    input  logic                  host_wen,
    input  logic [IDX_W-1:0]      host_idx,
    input  logic [15:0]           host_wdat,
    output logic                  host_wcoll,
    output logic [16*N_REGS-1:0]  regs_o,
    output logic [N_REGS-1:0]     reg_update,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [15:0]         regs_q   [N_REGS];
    logic [15:0]         shadow_q [N_REGS];
    logic [N_REGS-1:0]   pending_q;
    logic                err_q;
    logic                done_q;
    logic                status_q;
    logic [N_REGS-1:0]   update_q;
    logic                coll_q;
    logic [15:0]         rd_data_q;
    logic                rd_err_q;

    logic [15:0]         widx;
    logic [15:0]         ridx;
    logic [N_REGS-1:0]   wsel;
    logic                wlegal;
    logic                rvalid;
    logic [15:0]         rdat;
    logic [N_REGS-1:0]   host_mask;
    logic [N_REGS-1:0]   commit_mask;

    // 16-bit wrap makes addresses below BASE_ADDR land far out of range.
    assign widx = bus.reg_waddr - BASE_ADDR;
    assign ridx = bus.rd_addr - BASE_ADDR;

    always_comb begin
        wsel      = '0;
        wlegal    = 1'b0;
        rvalid    = 1'b0;
        rdat      = '0;
        host_mask = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (widx == 16'(i)) begin
                wsel[i] = 1'b1;
                wlegal  = WR_MASK[i];
            end
            if (ridx == 16'(i)) begin
                rvalid = 1'b1;
                rdat   = regs_q[i];
            end
            if (host_wen && (host_idx == IDX_W'(i))) begin
                host_mask[i] = 1'b1;
            end
        end
        commit_mask = (state_q == S_COMMIT && !err_q) ? pending_q : '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= 1'b0;
            update_q  <= '0;
            coll_q    <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i]   <= RESET_VALUES[16*i +: 16];
                shadow_q[i] <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            status_q <= 1'b0;
            update_q <= '0;
            // A committing index beats a simultaneous host write to it.
            coll_q   <= |(host_mask & commit_mask);
            for (int i = 0; i < N_REGS; i++) begin
                if (commit_mask[i]) begin
                    regs_q[i] <= shadow_q[i];
                end else if (host_mask[i]) begin
                    regs_q[i] <= host_wdat;
                end
            end

            if (bus.rd_en) begin
                rd_data_q <= rdat;
                rd_err_q  <= !rvalid;
            end

            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (bus.reg_wabort) begin
                        pending_q <= '0;
                        err_q     <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (bus.reg_wen) begin
                        if (wlegal) begin
                            for (int i = 0; i < N_REGS; i++) begin
                                if (wsel[i]) begin
                                    shadow_q[i] <= bus.reg_wdat;
                                end
                            end
                            pending_q <= pending_q | wsel;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= bus.reg_wlast ? S_COMMIT : S_COLLECT;
                    end
                end
                S_COMMIT: begin
                    done_q    <= 1'b1;
                    status_q  <= err_q;
                    update_q  <= commit_mask;
                    pending_q <= '0;
                    err_q     <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < N_REGS; i++) begin
            regs_o[16*i +: 16] = regs_q[i];
        end
    end

    assign bus.reg_w_done   = done_q;
    assign bus.reg_w_status = status_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_err       = rd_err_q;
    assign reg_update       = update_q;
    assign host_wcoll       = coll_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_modbus_holding_regs.sv
// Directed bench for modbus_holding_regs: 4 registers at 0x0010, index 2
// read-only, index 3 resetting to A5A5.
module tb_modbus_holding_regs;

    localparam int N = 4;
    localparam logic [63:0] RST_IMG = 64'hA5A5_0000_0000_0000;

    logic        clk_in;
    logic        rst_n_in;
    logic        host_wen;
    logic [1:0]  host_idx;
    logic [15:0] host_wdat;
    logic        host_wcoll;
    logic [63:0] regs_o;
    logic [3:0]  reg_update;
    logic [1:0]  dbg_state_o;

    int n_chk;
    int n_fail;

    modbus_holding_regs_if bus ();

    modbus_holding_regs #(
        .N_REGS       (N),
        .BASE_ADDR    (16'h0010),
        .RESET_VALUES (RST_IMG),
        .WR_MASK      (4'b1011)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .bus         (bus),
        .host_wen    (host_wen),
        .host_idx    (host_idx),
        .host_wdat   (host_wdat),
        .host_wcoll  (host_wcoll),
        .regs_o      (regs_o),
        .reg_update  (reg_update),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic beat(input logic [15:0] a, input logic [15:0] d, input logic last);
        bus.reg_wen   = 1'b1;
        bus.reg_waddr = a;
        bus.reg_wdat  = d;
        bus.reg_wlast = last;
        tick();
        bus.reg_wen   = 1'b0;
        bus.reg_wlast = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic st, input logic [3:0] upd, input logic [63:0] img);
        chk({tag, "_done"}, 64'(bus.reg_w_done), 64'd1);
        chk({tag, "_status"}, 64'(bus.reg_w_status), 64'(st));
        chk({tag, "_update"}, 64'(reg_update), 64'(upd));
        chk({tag, "_regs"}, regs_o, img);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n_in       = 1'b0;
        bus.reg_wen    = 1'b0;
        bus.reg_waddr  = '0;
        bus.reg_wdat   = '0;
        bus.reg_wlast  = 1'b0;
        bus.reg_wabort = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        host_wen       = 1'b0;
        host_idx       = '0;
        host_wdat      = '0;
        tick();
        tick();

        // reset state
        chk("rst_regs", regs_o, RST_IMG);
        chk("rst_done", 64'(bus.reg_w_done), 64'd0);
        chk("rst_status", 64'(bus.reg_w_status), 64'd0);
        chk("rst_update", 64'(reg_update), 64'd0);
        chk("rst_coll", 64'(host_wcoll), 64'd0);
        chk("rst_rdata", 64'(bus.rd_data), 64'd0);
        chk("rst_rerr", 64'(bus.rd_err), 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'd0);
        rst_n_in = 1'b1;
        tick();

        // reads: in range, one past the end, below base (wraps)
        rd(16'h0013);
        chk("rd13_data", 64'(bus.rd_data), 64'hA5A5);
        chk("rd13_err", 64'(bus.rd_err), 64'd0);
        tick();
        chk("rd13_hold", 64'(bus.rd_data), 64'hA5A5);
        rd(16'h0014);
        chk("rd14_data", 64'(bus.rd_data), 64'd0);
        chk("rd14_err", 64'(bus.rd_err), 64'd1);
        rd(16'h000F);
        chk("rd0f_err", 64'(bus.rd_err), 64'd1);

        // FC06 single beat: done exactly one cycle after the beat
        beat(16'h0011, 16'h1234, 1'b1);
        chk("fc06_state", 64'(dbg_state_o), 64'd2);
        chk("fc06_early", 64'(bus.reg_w_done), 64'd0);
        tick();
        chk_done("fc06", 1'b0, 4'b0010, 64'hA5A5_0000_1234_0000);
        tick();
        chk("fc06_done_w", 64'(bus.reg_w_done), 64'd0);
        chk("fc06_upd_w", 64'(reg_update), 64'd0);
        rd(16'h0011);
        chk("rd11_data", 64'(bus.rd_data), 64'h1234);

        // FC16 burst with repeated index: last beat wins, atomic commit
        beat(16'h0010, 16'h1111, 1'b0);
        chk("burst_state", 64'(dbg_state_o), 64'd1);
        beat(16'h0013, 16'h3333, 1'b0);
        beat(16'h0010, 16'h4444, 1'b1);
        chk("burst_shadow", regs_o, 64'hA5A5_0000_1234_0000);
        // read in the commit cycle sees the pre-commit value
        rd(16'h0010);
        chk("burst_rd_old", 64'(bus.rd_data), 64'h0000);
        chk_done("burst", 1'b0, 4'b1001, 64'h3333_0000_1234_4444);

        // burst touching read-only index 2: rejected, nothing copied
        beat(16'h0010, 16'hAAAA, 1'b0);
        beat(16'h0012, 16'hBBBB, 1'b1);
        tick();
        chk_done("ro", 1'b1, 4'b0000, 64'h3333_0000_1234_4444);

        // abort mid-burst
        beat(16'h0011, 16'h7777, 1'b0);
        bus.reg_wabort = 1'b1;
        tick();
        bus.reg_wabort = 1'b0;
        chk("abort_state", 64'(dbg_state_o), 64'd0);
        tick();
        chk("abort_done", 64'(bus.reg_w_done), 64'd0);
        chk("abort_regs", regs_o, 64'h3333_0000_1234_4444);
        // abort with a same-cycle last beat drops the beat
        bus.reg_wabort = 1'b1;
        beat(16'h0011, 16'hDEAD, 1'b1);
        bus.reg_wabort = 1'b0;
        tick();
        chk("abwen_done", 64'(bus.reg_w_done), 64'd0);
        chk("abwen_regs", regs_o, 64'h3333_0000_1234_4444);
        beat(16'h0011, 16'h8888, 1'b1);
        tick();
        chk_done("after_abort", 1'b0, 4'b0010, 64'h3333_0000_8888_4444);

        // host write colliding with the committing index loses
        beat(16'h0011, 16'h5555, 1'b1);
        host_wen  = 1'b1;
        host_idx  = 2'd1;
        host_wdat = 16'h9999;
        tick();
        host_wen = 1'b0;
        chk_done("coll", 1'b0, 4'b0010, 64'h3333_0000_5555_4444);
        chk("coll_flag", 64'(host_wcoll), 64'd1);

        // host write to another index in a commit cycle proceeds
        beat(16'h0011, 16'h6666, 1'b1);
        host_wen  = 1'b1;
        host_idx  = 2'd3;
        host_wdat = 16'h9999;
        tick();
        host_wen = 1'b0;
        chk_done("nocoll", 1'b0, 4'b0010, 64'h9999_0000_6666_4444);
        chk("nocoll_flag", 64'(host_wcoll), 64'd0);

        // host bypasses WR_MASK, no reg_update
        host_wen  = 1'b1;
        host_idx  = 2'd2;
        host_wdat = 16'h0C0D;
        tick();
        host_wen = 1'b0;
        chk("host_ro_regs", regs_o, 64'h9999_0C0D_6666_4444);
        chk("host_ro_upd", 64'(reg_update), 64'd0);
        chk("host_ro_done", 64'(bus.reg_w_done), 64'd0);

        // reset mid-burst discards it
        beat(16'h0013, 16'h1357, 1'b0);
        rst_n_in = 1'b0;
        #1;
        chk("rstmid_regs", regs_o, RST_IMG);
        chk("rstmid_state", 64'(dbg_state_o), 64'd0);
        tick();
        rst_n_in = 1'b1;
        tick();
        tick();
        chk("rstmid_done", 64'(bus.reg_w_done), 64'd0);
        chk("rstmid_regs2", regs_o, RST_IMG);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/modbus_holding_regs.md
# modbus_holding_regs

Parametrised Modbus holding-register bank: replaces the single hand-coded holding register in the RTU slave top with N registers behind the function handler's register write/read strobes. Multi-register writes (FC16) are staged in a shadow buffer and committed atomically only if every beat is legal. FC06 is a one-beat burst. A local host port lets fabric logic update registers, with a defined collision rule.

## Interface
Parameters:
- N_REGS, 8: number of 16-bit holding registers (1..64).
- BASE_ADDR, 16'h0000: Modbus address of register index 0.
- RESET_VALUES, {N_REGS{16'h0000}}: flat reset image; index i is bits [16i+15:16i].
- WR_MASK, {N_REGS{1'b1}}: bit i=1 means index i is Modbus-writable; 0 means read-only from Modbus.
- IDX_W, $clog2(N_REGS) (min 1): host index width.

Ports:
- clk_in, in, 1: system clock. Single clock domain.
- rst_n_in, in, 1: reset, asynchronous, active-low.
- reg_wen, in, 1: write beat valid.
- reg_waddr, in, 16: Modbus register address of the beat.
- reg_wdat, in, 16: beat data.
- reg_wlast, in, 1: final beat of the request; qualified by reg_wen.
- reg_wabort, in, 1: discard the pending burst (driven from the frame-drop path).
- reg_w_done, out, 1: one-cycle pulse when a request completes.
- reg_w_status, out, 1: valid with reg_w_done; 0 = committed, 1 = rejected (illegal address).
- rd_en, in, 1: read request.
- rd_addr, in, 16: Modbus register address to read.
- rd_data, out, 16: read data, registered.
- rd_err, out, 1: read address out of range, registered.
- host_wen, in, 1: local write strobe; bypasses WR_MASK.
- host_idx, in, IDX_W: local write index.
- host_wdat, in, 16: local write data.
- host_wcoll, out, 1: one-cycle pulse when a host write is lost to a commit.
- regs_o, out, 16*N_REGS: committed register image.
- reg_update, out, N_REGS: one-cycle per-register pulse on Modbus commit.

## Operation
- Beat index = reg_waddr − BASE_ADDR, using 16-bit unsigned wrap. A beat is illegal if index ≥ N_REGS or WR_MASK[index]=0. An illegal beat sets the sticky burst error.
- A legal beat writes shadow[index] and sets pending[index]. A repeated index overwrites; the last beat wins.
- States:
  - IDLE: first reg_wen goes to COLLECT, or straight to COMMIT if reg_wlast is also set.
  - COLLECT: accept beats; a beat with reg_wlast goes to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE.
- In COMMIT:
  - If there is no error, copy shadow into regs for every pending bit and pulse reg_update=pending.
  - On error, copy nothing and keep reg_update=0.
  - Always assert reg_w_done=1 and reg_w_status=error. Clear pending and error.
- reg_wen during COMMIT is ignored (dropped).
- reg_wabort in IDLE or COLLECT: clear pending and error, go to IDLE, no reg_w_done. reg_wabort in COMMIT is ignored; the commit completes.
- reg_wabort together with reg_wen on the same cycle: abort wins and the beat is dropped.
- Host write: regs[host_idx] = host_wdat at the clock edge. host_idx ≥ N_REGS is ignored. Host writes never pulse reg_update.
- Collision: a host write to an index being committed this cycle with pending=1 loses. The Modbus value is kept and host_wcoll pulses. A host write to any other index proceeds normally in the same cycle.
- Reads see committed regs only, never shadow. Out-of-range reads give rd_data=0 and rd_err=1.
- Reset values:
  - regs = RESET_VALUES, state IDLE, pending=0, error=0.
  - reg_w_done=0, reg_w_status=0, reg_update=0, host_wcoll=0, rd_data=0, rd_err=0.
- Reset mid-burst discards the burst; no done pulse after release.

## Timing
- Last beat sampled at edge E0 → COMMIT during the cycle after E0 → regs_o, reg_update and reg_w_done all change at E1.
- Single FC06 write: reg_w_done appears 1 cycle after the beat.
- reg_update and reg_w_done are exactly one cycle wide and coincide.
- Read: rd_en at edge E0 → rd_data/rd_err valid from E0 until the next rd_en. A read in the commit cycle returns the pre-commit value.
- Host write: visible on regs_o one cycle after host_wen.
- Beats may be back-to-back every cycle or have gaps of any length.

## Test plan
Test configuration: N_REGS=4, BASE_ADDR=16'h0010, WR_MASK=4'b1011, RESET_VALUES all 16'h0000 except index3=16'hA5A5.
- After reset: regs_o = {A5A5,0000,0000,0000}; rd_en to 0x0013 → rd_data=A5A5, rd_err=0; rd_en to 0x0014 → rd_data=0, rd_err=1.
- FC06 beat (0x0011, 1234, wlast) → next cycle reg_w_done=1, status=0, reg_update=4'b0010, regs[1]=1234.
- Burst of beats (0x0010,1111), (0x0013,3333), (0x0010,4444,wlast) → regs[0]=4444, regs[3]=3333, reg_update=4'b1001, status=0.
- Burst (0x0010,AAAA), (0x0012,BBBB,wlast): index 2 is read-only → status=1, regs unchanged, reg_update=0.
- Burst (0x0011,7777), then reg_wabort → no done pulse and regs[1] unchanged; a following FC06 (0x0011,8888) commits normally.
- host_wen idx=1 data=9999 on the commit cycle of FC06 (0x0011,5555) → regs[1]=5555, host_wcoll=1. The same host write to idx 3 in the same cycle → regs[3]=9999, host_wcoll=0.
